// File: rtl/scope_pkg.sv
// Shared oscilloscope display constants, colours and pixel bundle type.
// The optional graticule is enabled by defining TRACE_GRID_EN.
package scope_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;
    localparam int SAMPLE_W = 14;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;

    // A full-scale 14-bit sample spans about 512 rows after this shift.
    localparam int ROW_SHIFT = SAMPLE_W - Y_W + 1;

    localparam logic [23:0] TRACE_COLOUR = 24'hFFFF00;
    localparam logic [23:0] GRID_COLOUR  = 24'h404040;
    localparam logic [23:0] BG_COLOUR    = 24'h000000;

    localparam int unsigned GRID_DX = 100;
    localparam int unsigned GRID_DY = 60;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pixel_t;

    function automatic logic in_span(input logic [Y_W-1:0] a,
                                     input logic [Y_W-1:0] b,
                                     input logic [Y_W-1:0] y);
        logic [Y_W-1:0] lo;
        logic [Y_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (y >= lo) && (y <= hi);
    endfunction

endpackage

// File: rtl/trace_row_scale.sv
// Combinational sample-to-screen-row conversion: sample 0 lands on the
// bottom row, large samples saturate at the top row.
module trace_row_scale
    import scope_pkg::*;
(
    input  logic [SAMPLE_W-1:0] sample,
    output logic [Y_W-1:0]      row
);

    localparam logic [SAMPLE_W-1:0] ROW_MAX = SAMPLE_W'(V_ACTIVE - 1);

    logic [SAMPLE_W-1:0] shifted;

    always_comb begin
        shifted = sample >> ROW_SHIFT;
        row     = '0;
        if (shifted <= ROW_MAX) begin
            row = Y_W'(ROW_MAX - shifted);
        end
    end

endmodule

// File: rtl/trace_renderer.sv
// Three-stage pixel pipeline turning buffered samples into a joined RGB trace.
// Define TRACE_GRID_EN to draw a graticule behind the trace.
module trace_renderer
    import scope_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [X_W-1:0]      pixelX,
    input  logic [Y_W-1:0]      pixelY,
    input  logic                pixelValid,
    output logic [X_W-1:0]      screenX,
    input  logic [SAMPLE_W-1:0] screenData,
    output logic [23:0]         rgb,
    output logic                rgbValid
);

    pixel_t         s1;
    pixel_t         s2;
    logic           s2_valid_prev;
    logic [Y_W-1:0] prev_row;
    logic [Y_W-1:0] row;
    logic [Y_W-1:0] join_row;
    logic           col_start;
    logic           hit;
    logic [23:0]    bg;
    logic [23:0]    pix_colour;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1      <= '0;
            screenX <= '0;
        end else begin
            s1      <= '{valid: pixelValid, x: pixelX, y: pixelY};
            screenX <= (pixelX >= X_W'(H_ACTIVE)) ? X_W'(H_ACTIVE - 1) : pixelX;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2 <= '0;
        end else begin
            s2 <= s1;
        end
    end

    trace_row_scale u_row_scale (
        .sample (screenData),
        .row    (row)
    );

    // Column 0 or a valid rising edge starts a fresh segment with no join.
    always_comb begin
        col_start = (s2.x == '0) || !s2_valid_prev;
        join_row  = col_start ? row : prev_row;
        hit       = in_span(join_row, row, s2.y);
    end

`ifdef TRACE_GRID_EN
    logic on_grid;

    always_comb begin
        on_grid = ((32'(s2.x) % GRID_DX) == 32'd0) ||
                  ((32'(s2.y) % GRID_DY) == 32'd0) ||
                  (s2.x == X_W'(H_ACTIVE - 1))     ||
                  (s2.y == Y_W'(V_ACTIVE - 1));
        bg = on_grid ? GRID_COLOUR : BG_COLOUR;
    end
`else
    assign bg = BG_COLOUR;
`endif

    always_comb begin
        pix_colour = 24'h000000;
        if (s2.valid) begin
            pix_colour = hit ? TRACE_COLOUR : bg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb           <= '0;
            rgbValid      <= 1'b0;
            s2_valid_prev <= 1'b0;
            prev_row      <= Y_W'(V_ACTIVE - 1);
        end else begin
            rgb           <= pix_colour;
            rgbValid      <= s2.valid;
            s2_valid_prev <= s2.valid;
            if (s2.valid) begin
                prev_row <= row;
            end
        end
    end

endmodule

// File: tb/tb_trace_renderer.sv
// Directed self-checking bench for trace_renderer with a 1-cycle sample buffer model.
module tb_trace_renderer;

    logic        clock;
    logic        reset;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;
    logic        pixelValid;
    logic [10:0] screenX;
    logic [13:0] screenData;
    logic [23:0] rgb;
    logic        rgbValid;

    int total;
    int bad;
    int dataMode;

    localparam logic [23:0] TRACE = 24'hFFFF00;
`ifdef TRACE_GRID_EN
    localparam logic [23:0] GRIDBG = 24'h404040;
`else
    localparam logic [23:0] GRIDBG = 24'h000000;
`endif

    trace_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .pixelValid (pixelValid),
        .screenX    (screenX),
        .screenData (screenData),
        .rgb        (rgb),
        .rgbValid   (rgbValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sample buffer: mode 0 flat zero, mode 1 ramp x*20, mode 2 step at column 400.
    function automatic logic [13:0] bufModel(input logic [10:0] x, input int mode);
        case (mode)
            1:       return 14'(int'(x) * 20);
            2:       return (x >= 11'd400) ? 14'd16383 : 14'd0;
            default: return 14'd0;
        endcase
    endfunction

    always @(posedge clock) screenData <= bufModel(screenX, dataMode);

    function automatic logic [31:0] px(input logic v, input logic [23:0] c);
        return {7'd0, v, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] x, input logic [9:0] y, input logic v);
        pixelX     = x;
        pixelY     = y;
        pixelValid = v;
        @(posedge clock);
        #1;
    endtask

    logic [9:0]  rampY   [4] = '{10'd472, 10'd473, 10'd474, 10'd475};
    logic [23:0] exp9    [4] = '{24'h0, 24'h0, TRACE, 24'h0};
    logic [23:0] exp10   [4] = '{24'h0, TRACE, TRACE, 24'h0};
    logic [9:0]  stepY   [3] = '{10'd0, 10'd240, 10'd479};
    logic [23:0] exp399  [3] = '{GRIDBG, GRIDBG, TRACE};

    initial begin
        total      = 0;
        bad        = 0;
        dataMode   = 0;
        reset      = 1'b1;
        pixelX     = '0;
        pixelY     = '0;
        pixelValid = 1'b0;
        #1;
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("reset_out", px(rgbValid, rgb), px(0, 24'h0));
        checkOutput("reset_screenX", {21'd0, screenX}, 32'd0);
        reset = 1'b0;

        // Flat zero data: bottom row lit on every column, row above dark.
        for (int i = 0; i < 23; i++) begin
            if (i < 20) applyStimulus(11'(i), 479, 1);
            else        applyStimulus(0, 0, 0);
            if (i >= 2)
                checkOutput(i < 22 ? "flat_bottom" : "flat_blank", px(rgbValid, rgb),
                            i < 22 ? px(1, TRACE) : px(0, 24'h0));
        end
        for (int i = 0; i < 21; i++) begin
            if (i < 19) applyStimulus(11'(i + 1), 478, 1);
            else        applyStimulus(0, 0, 0);
            if (i >= 2) checkOutput("flat_row478", px(rgbValid, rgb), px(1, 24'h0));
        end

        // Ramp data: column 9 row 474, column 10 row 473 joined to 474.
        dataMode = 1;
        repeat (2) applyStimulus(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(9, rampY[k], 1);
            applyStimulus(10, rampY[k], 1);
            checkOutput("ramp_addr", {21'd0, screenX}, 32'd10);
            applyStimulus(0, 0, 0);
            checkOutput("ramp_col9", px(rgbValid, rgb), px(1, exp9[k]));
            applyStimulus(0, 0, 0);
            checkOutput("ramp_col10", px(rgbValid, rgb), px(1, exp10[k]));
        end

        // Step data: column 400 joins bottom to top.
        dataMode = 2;
        repeat (2) applyStimulus(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(399, stepY[k], 1);
            applyStimulus(400, stepY[k], 1);
            applyStimulus(0, 0, 0);
            checkOutput("step_col399", px(rgbValid, rgb), px(1, exp399[k]));
            applyStimulus(0, 0, 0);
            checkOutput("step_col400", px(rgbValid, rgb), px(1, TRACE));
        end
        applyStimulus(401, 0, 1);
        applyStimulus(402, 1, 1);
        applyStimulus(403, 1, 1);
        checkOutput("step_top401", px(rgbValid, rgb), px(1, TRACE));
        applyStimulus(0, 0, 0);
        checkOutput("step_flat402", px(rgbValid, rgb), px(1, 24'h0));
        applyStimulus(0, 0, 0);
        checkOutput("step_flat403", px(rgbValid, rgb), px(1, 24'h0));
        applyStimulus(0, 0, 0);

        // A blanking gap between 399 and 400 must not bridge the step.
        applyStimulus(399, 240, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(400, 240, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("gap_no_join", px(rgbValid, rgb), px(1, GRIDBG));

        // Column clamp and invalid pixel three cycles later.
        applyStimulus(850, 0, 1);
        checkOutput("clamp_addr", {21'd0, screenX}, 32'd799);
        applyStimulus(5, 479, 0);
        applyStimulus(0, 0, 0);
        checkOutput("clamp_pixel", px(rgbValid, rgb), px(1, TRACE));
        applyStimulus(0, 0, 0);
        checkOutput("valid_low", px(rgbValid, rgb), px(0, 24'h0));

        // Reset mid-line: three black cycles, then no join to old history.
        dataMode = 1;
        repeat (2) applyStimulus(0, 0, 0);
        applyStimulus(100, 417, 1);
        applyStimulus(101, 416, 1);
        reset = 1'b1;
        applyStimulus(102, 0, 1);
        reset = 1'b0;
        checkOutput("rst_screenX", {21'd0, screenX}, 32'd0);
        checkOutput("rst_black0", px(rgbValid, rgb), px(0, 24'h0));
        applyStimulus(201, 400, 1);
        checkOutput("rst_black1", px(rgbValid, rgb), px(0, 24'h0));
        applyStimulus(202, 354, 1);
        checkOutput("rst_black2", px(rgbValid, rgb), px(0, 24'h0));
        applyStimulus(0, 0, 0);
        checkOutput("rst_unjoined", px(rgbValid, rgb), px(1, 24'h0));
        applyStimulus(0, 0, 0);
        checkOutput("rst_rejoin", px(rgbValid, rgb), px(1, TRACE));

        // Graticule point off and on the trace (column 100 sits on row 417).
        applyStimulus(100, 200, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("grid_off_trace", px(rgbValid, rgb), px(1, GRIDBG));
        applyStimulus(100, 417, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("grid_on_trace", px(rgbValid, rgb), px(1, TRACE));

        // Column 0 restarts the join even while valid stays high.
        applyStimulus(5, 477, 1);
        applyStimulus(0, 477, 1);
        applyStimulus(0, 0, 0);
        checkOutput("col5_start", px(rgbValid, rgb), px(1, 24'h0));
        applyStimulus(0, 0, 0);
        checkOutput("col0_restart", px(rgbValid, rgb), px(1, GRIDBG));
        applyStimulus(0, 479, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("col0_rise", px(rgbValid, rgb), px(1, TRACE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
